// File: rtl/fb_fetch_pkg.sv
// Shared definitions for the frame-buffer fetch sequencer: FSM state encoding
// and the width derivations used by the sequencer and its address generator.
package fb_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BUF = 3'd1,
    REQ      = 3'd2,
    DATA     = 3'd3,
    NEXT     = 3'd4
  } fetch_state_e;

  // Bytes per read beat / buffer word.
  function automatic int bpb(input int data_width);
    return data_width / 8;
  endfunction

  // Width of a burst beat count, 1..burst_len inclusive.
  function automatic int len_w(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

  // Width of a word index inside one ping-pong half.
  function automatic int idx_w(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/fb_fetch_addr_gen.sv
// Frame address walker: holds the current burst address and latched frame end,
// derives the next burst length and whether that burst finishes the frame.
module fb_fetch_addr_gen
  import fb_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          load,
  input  logic [ADDR_WIDTH-1:0]         base,
  input  logic [ADDR_WIDTH-1:0]         top,
  input  logic                          advance,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic [len_w(BURST_LEN)-1:0]   len,
  output logic                          last
);

  localparam int BPB   = bpb(DATA_WIDTH);
  localparam int OFF   = $clog2(BPB);
  localparam int LEN_W = len_w(BURST_LEN);

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] top_reg;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] end_addr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_reg <= '0;
      top_reg  <= '0;
    end else if (load) begin
      addr_reg <= base;
      top_reg  <= top;
    end else if (advance) begin
      addr_reg <= end_addr;
    end
  end

  // Only meaningful while addr_reg < top_reg, which the sequencer guarantees.
  always_comb begin
    remaining = (top_reg - addr_reg) >> OFF;
    if (remaining >= ADDR_WIDTH'(BURST_LEN)) begin
      len = LEN_W'(BURST_LEN);
    end else begin
      len = remaining[LEN_W-1:0];
    end
    step     = ADDR_WIDTH'(len) << OFF;
    end_addr = addr_reg + step;
    last     = (end_addr >= top_reg);
  end

  assign addr = addr_reg;

endmodule

// File: rtl/fb_fetch_ctrl.sv
// Frame-buffer fetch sequencer: walks [base, top) in bursts into a ping-pong
// line buffer. Optional underrun counter via FB_FETCH_UNDERRUN_CNT_EN.
module fb_fetch_ctrl
  import fb_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [ADDR_WIDTH-1:0]       base_addr_i,
  input  logic [ADDR_WIDTH-1:0]       top_addr_i,
  input  logic                        enable_i,
  input  logic                        frame_start_i,
  input  logic [1:0]                  buf_free_i,
  output logic                        rd_req_o,
  output logic [ADDR_WIDTH-1:0]       rd_addr_o,
  output logic [len_w(BURST_LEN)-1:0] rd_len_o,
  input  logic                        rd_gnt_i,
  input  logic                        rd_valid_i,
  input  logic [DATA_WIDTH-1:0]       rd_data_i,
  output logic                        buf_we_o,
  output logic                        buf_sel_o,
  output logic [idx_w(BURST_LEN)-1:0] buf_waddr_o,
  output logic [DATA_WIDTH-1:0]       buf_wdata_o,
  output logic [1:0]                  buf_fill_o,
  output logic                        frame_done_o,
  output logic                        underrun_o,
`ifdef FB_FETCH_UNDERRUN_CNT_EN
  output logic [15:0]                 underrun_cnt_o,
`endif
  output logic                        busy_o
);

  localparam int BPB   = bpb(DATA_WIDTH);
  localparam int LEN_W = len_w(BURST_LEN);
  localparam int IDX_W = idx_w(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BPB - 1);

  fetch_state_e state_reg, state_next;

  logic                  half_reg, half_next;
  logic [1:0]            full_reg, full_next, full_set;
  logic                  pend_reg, pend_next;
  logic [IDX_W-1:0]      beat_reg, beat_next;
  logic                  rd_req_reg, rd_req_next;
  logic [ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
  logic [LEN_W-1:0]      rd_len_reg, rd_len_next;
  logic                  we_reg, we_next;
  logic                  sel_reg, sel_next;
  logic [IDX_W-1:0]      waddr_reg, waddr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [1:0]            fill_reg;
  logic                  done_reg, done_next;
  logic                  underrun_reg;

  logic [ADDR_WIDTH-1:0] base_aligned;
  logic [ADDR_WIDTH-1:0] top_aligned;
  logic                  frame_empty;
  logic                  accept;
  logic                  start_busy;
  logic                  restart;
  logic                  granted;
  logic                  last_beat;
  logic                  load_frame;

  logic [ADDR_WIDTH-1:0] ag_addr;
  logic [LEN_W-1:0]      ag_len;
  logic                  ag_last;

  assign base_aligned = base_addr_i & ALIGN_MASK;
  assign top_aligned  = top_addr_i & ALIGN_MASK;
  assign frame_empty  = (top_aligned <= base_aligned);
  assign accept       = (state_reg == IDLE) && enable_i && (frame_start_i || pend_reg);
  assign start_busy   = frame_start_i && (state_reg != IDLE);
  assign restart      = pend_reg || start_busy;
  assign granted      = rd_req_reg && rd_gnt_i;
  assign last_beat    = (LEN_W'(beat_reg) + LEN_W'(1)) == rd_len_reg;

  fb_fetch_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_LEN  (BURST_LEN)
  ) u_addr_gen (
    .clk     (clk),
    .resetn  (resetn),
    .load    (load_frame),
    .base    (base_aligned),
    .top     (top_aligned),
    .advance (state_reg == NEXT),
    .addr    (ag_addr),
    .len     (ag_len),
    .last    (ag_last)
  );

  // A set from NEXT wins over a same-cycle release of that half.
  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign full_set[gi]  = (state_reg == NEXT) && (int'(half_reg) == gi);
    assign full_next[gi] = full_set[gi] | (full_reg[gi] & ~buf_free_i[gi]);
  end

  always_comb begin
    state_next   = state_reg;
    half_next    = half_reg;
    pend_next    = pend_reg | start_busy;
    beat_next    = beat_reg;
    rd_req_next  = 1'b0;
    rd_addr_next = rd_addr_reg;
    rd_len_next  = rd_len_reg;
    we_next      = 1'b0;
    sel_next     = sel_reg;
    waddr_next   = waddr_reg;
    wdata_next   = wdata_reg;
    done_next    = 1'b0;
    load_frame   = 1'b0;

    case (state_reg)
      IDLE: begin
        // A pending restart is consumed here whether or not enable_i admits it.
        pend_next = 1'b0;
        if (accept) begin
          half_next = 1'b0;
          if (frame_empty) begin
            done_next = 1'b1;
          end else begin
            load_frame = 1'b1;
            state_next = WAIT_BUF;
          end
        end
      end

      WAIT_BUF: begin
        if (restart) begin
          state_next = IDLE;
        end else if (!(full_reg[half_reg] && !buf_free_i[half_reg])) begin
          state_next = REQ;
        end
      end

      REQ: begin
        if (granted) begin
          state_next = DATA;
          beat_next  = '0;
        end else if (restart) begin
          state_next = IDLE;
        end else begin
          rd_req_next = 1'b1;
          if (!rd_req_reg) begin
            rd_addr_next = ag_addr;
            rd_len_next  = ag_len;
          end
        end
      end

      DATA: begin
        if (rd_valid_i) begin
          we_next    = 1'b1;
          sel_next   = half_reg;
          waddr_next = beat_reg;
          wdata_next = rd_data_i;
          if (last_beat) begin
            state_next = restart ? IDLE : NEXT;
          end else begin
            beat_next = beat_reg + IDX_W'(1);
          end
        end
      end

      NEXT: begin
        half_next  = ~half_reg;
        done_next  = ag_last;
        state_next = ag_last ? IDLE : WAIT_BUF;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      half_reg     <= 1'b0;
      full_reg     <= 2'b00;
      pend_reg     <= 1'b0;
      beat_reg     <= '0;
      rd_req_reg   <= 1'b0;
      rd_addr_reg  <= '0;
      rd_len_reg   <= '0;
      we_reg       <= 1'b0;
      sel_reg      <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      fill_reg     <= 2'b00;
      done_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      half_reg     <= half_next;
      full_reg     <= full_next;
      pend_reg     <= pend_next;
      beat_reg     <= beat_next;
      rd_req_reg   <= rd_req_next;
      rd_addr_reg  <= rd_addr_next;
      rd_len_reg   <= rd_len_next;
      we_reg       <= we_next;
      sel_reg      <= sel_next;
      waddr_reg    <= waddr_next;
      wdata_reg    <= wdata_next;
      fill_reg     <= full_set;
      done_reg     <= done_next;
      underrun_reg <= start_busy;
    end
  end

`ifdef FB_FETCH_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      underrun_cnt_reg <= '0;
    end else if (start_busy && (underrun_cnt_reg != 16'hFFFF)) begin
      underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
    end
  end

  assign underrun_cnt_o = underrun_cnt_reg;
`endif

  assign rd_req_o     = rd_req_reg;
  assign rd_addr_o    = rd_addr_reg;
  assign rd_len_o     = rd_len_reg;
  assign buf_we_o     = we_reg;
  assign buf_sel_o    = sel_reg;
  assign buf_waddr_o  = waddr_reg;
  assign buf_wdata_o  = wdata_reg;
  assign buf_fill_o   = fill_reg;
  assign frame_done_o = done_reg;
  assign underrun_o   = underrun_reg;
  assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_fb_fetch_ctrl.sv
// Bench for fb_fetch_ctrl: random memory responder plus a frame-level model
// that lists the expected requests, buffer writes and fill/done pulses.
module tb_fb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [31:0] top_addr_i = '0;
  logic        enable_i = 1'b0;
  logic        frame_start_i = 1'b0;
  wire  [1:0]  buf_free_i;
  logic        rd_req_o;
  logic [31:0] rd_addr_o;
  logic [4:0]  rd_len_o;
  logic        rd_gnt_i = 1'b0;
  logic        rd_valid_i = 1'b0;
  logic [31:0] rd_data_i = '0;
  logic        buf_we_o;
  logic        buf_sel_o;
  logic [3:0]  buf_waddr_o;
  logic [31:0] buf_wdata_o;
  logic [1:0]  buf_fill_o;
  logic        frame_done_o;
  logic        underrun_o;
  logic        busy_o;
`ifdef FB_FETCH_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_o;
`endif

  fb_fetch_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(16)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .base_addr_i    (base_addr_i),
    .top_addr_i     (top_addr_i),
    .enable_i       (enable_i),
    .frame_start_i  (frame_start_i),
    .buf_free_i     (buf_free_i),
    .rd_req_o       (rd_req_o),
    .rd_addr_o      (rd_addr_o),
    .rd_len_o       (rd_len_o),
    .rd_gnt_i       (rd_gnt_i),
    .rd_valid_i     (rd_valid_i),
    .rd_data_i      (rd_data_i),
    .buf_we_o       (buf_we_o),
    .buf_sel_o      (buf_sel_o),
    .buf_waddr_o    (buf_waddr_o),
    .buf_wdata_o    (buf_wdata_o),
    .buf_fill_o     (buf_fill_o),
    .frame_done_o   (frame_done_o),
    .underrun_o     (underrun_o),
`ifdef FB_FETCH_UNDERRUN_CNT_EN
    .underrun_cnt_o (underrun_cnt_o),
`endif
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [4:0] len; } req_t;
  typedef struct packed { logic sel; logic [3:0] idx; logic [31:0] data; } wr_t;
  typedef struct packed { logic [1:0] fill; logic done; } fill_t;

  req_t  exp_req[$];
  wr_t   exp_wr[$];
  fill_t exp_fill[$];

  int          n_checks = 0;
  int          n_errors = 0;
  bit          auto_free = 1'b1;
  logic [1:0]  manual_free = 2'b00;
  bit          gnt_en = 1'b1;
  bit          gaps = 1'b0;
  logic [31:0] salt = '0;
  int          beats_left = 0;
  int          issued = 0;
  int          cur_beat = -1;
  logic [31:0] cur_addr = '0;
  int          ur_seen = 0;
  int          req_seen = 0;
  int          fill_seen = 0;
  logic        prev_req = 1'b0;

  // Display side releases a half as soon as it is reported filled.
  assign buf_free_i = (auto_free ? buf_fill_o : 2'b00) | manual_free;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int i);
    return (a + 32'(i) * 32'd4) ^ salt;
  endfunction

  // Expected transactions of one frame, from the burst-splitting rule.
  task automatic plan_frame(input logic [31:0] b_in, input logic [31:0] t_in);
    logic [31:0] b, t, a;
    int          len;
    logic        h;
    req_t        r;
    wr_t         w;
    fill_t       f;
    b = b_in & ~32'h3;
    t = t_in & ~32'h3;
    if (t <= b) begin
      f.fill = 2'b00; f.done = 1'b1;
      exp_fill.push_back(f);
    end else begin
      a = b;
      h = 1'b0;
      while (a < t) begin
        len = ((t - a) / 4 > 32'd16) ? 16 : int'((t - a) / 4);
        r.addr = a; r.len = 5'(len);
        exp_req.push_back(r);
        for (int i = 0; i < len; i++) begin
          w.sel = h; w.idx = 4'(i); w.data = beat_data(a, i);
          exp_wr.push_back(w);
        end
        a = a + 32'(len * 4);
        f.fill = h ? 2'b10 : 2'b01;
        f.done = (a >= t);
        exp_fill.push_back(f);
        h = ~h;
      end
    end
  endtask

  // Memory side: random grant delay, optional gaps between beats.
  initial begin
    forever begin
      @(negedge clk);
      rd_gnt_i   = 1'b0;
      rd_valid_i = 1'b0;
      if (!resetn) begin
        beats_left = 0;
        cur_beat   = -1;
      end else if (beats_left > 0) begin
        if (!gaps || $urandom_range(0, 2) != 0) begin
          cur_beat   = issued;
          rd_valid_i = 1'b1;
          rd_data_i  = beat_data(cur_addr, issued);
          issued++;
          beats_left--;
        end
      end else if (rd_req_o && gnt_en && $urandom_range(0, 1) == 0) begin
        rd_gnt_i   = 1'b1;
        cur_addr   = rd_addr_o;
        beats_left = int'(rd_len_o);
        issued     = 0;
      end
    end
  end

  // Monitor: every observed transaction is matched against the model queues.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_req <= 1'b0;
    end else begin
      prev_req <= rd_req_o;
      if (rd_req_o && !prev_req) begin
        req_seen++;
        $display("[%0t] req addr=0x%08h len=%0d", $time, rd_addr_o, rd_len_o);
        check("req_expected", 64'(exp_req.size() > 0), 64'(1));
        if (exp_req.size() > 0) check("req", 64'({rd_addr_o, rd_len_o}), 64'(exp_req.pop_front()));
      end
      if (buf_we_o) begin
        check("wr_expected", 64'(exp_wr.size() > 0), 64'(1));
        if (exp_wr.size() > 0) check("wr", 64'({buf_sel_o, buf_waddr_o, buf_wdata_o}), 64'(exp_wr.pop_front()));
      end
      if (buf_fill_o != 2'b00 || frame_done_o) begin
        if (buf_fill_o != 2'b00) fill_seen++;
        $display("[%0t] fill=%b done=%b", $time, buf_fill_o, frame_done_o);
        check("fill_expected", 64'(exp_fill.size() > 0), 64'(1));
        if (exp_fill.size() > 0) check("fill_done", 64'({buf_fill_o, frame_done_o}), 64'(exp_fill.pop_front()));
      end
      if (underrun_o) ur_seen++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [31:0] b, input logic [31:0] t);
    base_addr_i   = b;
    top_addr_i    = t;
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while ((exp_req.size() > 0 || exp_wr.size() > 0 || exp_fill.size() > 0 || busy_o) && k < 3000) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, 64'(k < 3000), 64'(1));
  endtask

  initial begin
    int   r0, f0, u0, k;
    req_t r;
    wr_t  w;
    logic [31:0] b, t;

    salt = $urandom;
    repeat (3) tick();
    check("reset_ctrl", 64'({rd_req_o, rd_len_o, buf_we_o, buf_sel_o, buf_waddr_o, buf_fill_o,
                             frame_done_o, underrun_o, busy_o}), 64'(0));
    check("reset_data", 64'({rd_addr_o, buf_wdata_o}), 64'(0));
    resetn   = 1'b1;
    enable_i = 1'b1;
    tick();

    // Full frame: four 16-beat bursts alternating halves.
    r0 = req_seen;
    plan_frame(32'h1000, 32'h1100);
    start_frame(32'h1000, 32'h1100);
    wait_done("full");
    check("full_reqs", 64'(req_seen - r0), 64'(4));

    // Partial frame: one 10-beat burst.
    plan_frame(32'h1000, 32'h1028);
    start_frame(32'h1000, 32'h1028);
    wait_done("partial");

    // Empty frame: done pulse one cycle after the start, never busy.
    r0 = req_seen;
    plan_frame(32'h2000, 32'h2000);
    start_frame(32'h2000, 32'h2000);
    check("empty_done", 64'(frame_done_o), 64'(1));
    check("empty_busy", 64'(busy_o), 64'(0));
    tick();
    check("empty_busy2", 64'(busy_o), 64'(0));
    check("empty_noreq", 64'(req_seen - r0), 64'(0));

    // Start ignored while disabled.
    enable_i = 1'b0;
    start_frame(32'h1000, 32'h1100);
    repeat (5) tick();
    check("disabled_busy", 64'(busy_o), 64'(0));
    enable_i = 1'b1;

    // Back-pressure: halves are not released until told.
    auto_free = 1'b0;
    r0 = req_seen;
    f0 = fill_seen;
    plan_frame(32'h1000, 32'h1100);
    start_frame(32'h1000, 32'h1100);
    k = 0;
    while (fill_seen < f0 + 2 && k < 2000) begin tick(); k++; end
    check("bp_fill_timeout", 64'(k < 2000), 64'(1));
    repeat (20) tick();
    check("bp_hold_req", 64'(rd_req_o), 64'(0));
    check("bp_hold_busy", 64'(busy_o), 64'(1));
    check("bp_hold_reqs", 64'(req_seen - r0), 64'(2));
    manual_free = 2'b01;
    k = 0;
    do begin
      tick();
      k++;
      if (k == 1) manual_free = 2'b00;
    end while (!rd_req_o && k < 10);
    check("bp_latency_ok", 64'(k <= 2), 64'(1));
    auto_free   = 1'b1;
    manual_free = 2'b10;
    tick();
    manual_free = 2'b00;
    wait_done("bp");

    // Restart during the fifth data beat: drain, no fill, refetch from base.
    gaps = 1'b0;
    u0   = ur_seen;
    r.addr = 32'h1000; r.len = 5'd16;
    exp_req.push_back(r);
    for (int i = 0; i < 16; i++) begin
      w.sel = 1'b0; w.idx = 4'(i); w.data = beat_data(32'h1000, i);
      exp_wr.push_back(w);
    end
    plan_frame(32'h1000, 32'h1100);
    start_frame(32'h1000, 32'h1100);
    k = 0;
    while (!(rd_valid_i && cur_beat == 4) && k < 500) begin tick(); k++; end
    check("restart_beat_timeout", 64'(k < 500), 64'(1));
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    wait_done("restart");
    check("restart_underruns", 64'(ur_seen - u0), 64'(1));
`ifdef FB_FETCH_UNDERRUN_CNT_EN
    check("restart_cnt", 64'(underrun_cnt_o), 64'(1));
`endif

    // Reset while a request is outstanding.
    gnt_en = 1'b0;
    r.addr = 32'h1000; r.len = 5'd16;
    exp_req.push_back(r);
    start_frame(32'h1000, 32'h1100);
    k = 0;
    while (!rd_req_o && k < 100) begin tick(); k++; end
    check("rst_req_timeout", 64'(k < 100), 64'(1));
    resetn = 1'b0;
    tick();
    check("rst_req_low", 64'(rd_req_o), 64'(0));
    check("rst_busy_low", 64'(busy_o), 64'(0));
`ifdef FB_FETCH_UNDERRUN_CNT_EN
    check("rst_cnt", 64'(underrun_cnt_o), 64'(0));
`endif
    resetn = 1'b1;
    gnt_en = 1'b1;
    tick();
    plan_frame(32'h1000, 32'h1040);
    start_frame(32'h1000, 32'h1040);
    wait_done("post_reset");

    // Random frames, including unaligned base, empty and inverted windows.
    gaps = 1'b1;
    for (int n = 0; n < 10; n++) begin
      salt = $urandom;
      b = 32'($urandom_range(0, 16'h3FFF)) << 2;
      case ($urandom_range(0, 4))
        0:       t = b;
        1:       t = b - 32'd8;
        default: t = b + 32'($urandom_range(1, 70)) * 32'd4;
      endcase
      b = b | 32'($urandom_range(0, 3));
      plan_frame(b, t);
      start_frame(b, t);
      wait_done("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fb_fetch_ctrl.md
# fb_fetch_ctrl

Frame-buffer fetch sequencer for the VGA pipeline. Once per frame it walks the memory window [base_addr, top_addr) from the config unit in fixed-size read bursts, and fills the two halves of the ping-pong line buffer alternately. Each half is filled only after the display side has released it. The block sits between the memory read port (via the system arbiter) and the Ping Pong Register.

## Interface
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, read-data / buffer word width (bytes per beat BPB = DATA_WIDTH/8)
- BURST_LEN, 16, max beats per burst, equal to words per ping-pong half (power of two)
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- base_addr_i  in  ADDR_WIDTH  frame start byte address (BPB-aligned; low bits ignored)
- top_addr_i  in  ADDR_WIDTH  frame end byte address, exclusive (BPB-aligned)
- enable_i  in  1  fetch allowed; low = frame_start_i ignored
- frame_start_i  in  1  one-cycle pulse at vertical blank
- buf_free_i  in  2  per-half release pulse from display side
- rd_req_o  out  1  burst request
- rd_addr_o  out  ADDR_WIDTH  burst byte address
- rd_len_o  out  clog2(BURST_LEN)+1  burst beat count, 1..BURST_LEN
- rd_gnt_i  in  1  request accepted
- rd_valid_i  in  1  read beat valid
- rd_data_i  in  DATA_WIDTH  read beat data
- buf_we_o  out  1  buffer write enable
- buf_sel_o  out  1  target half
- buf_waddr_o  out  clog2(BURST_LEN)  word index in the half
- buf_wdata_o  out  DATA_WIDTH  write data
- buf_fill_o  out  2  per-half "filled" pulse
- frame_done_o  out  1  pulse after the frame's last fill
- underrun_o  out  1  pulse: frame_start_i arrived while busy
- busy_o  out  1  state != IDLE

## Operation
- The frame start/end addresses are latched on an accepted frame_start_i (IDLE && enable_i). Config changes mid-frame have no effect.
- States:
  - IDLE: on accepted start, go to WAIT_BUF. If top <= base, emit frame_done_o and stay in IDLE.
  - WAIT_BUF: wait until full[half] == 0, then go to REQ.
  - REQ: hold rd_req_o, rd_addr_o and rd_len_o stable until rd_gnt_i, then go to DATA.
  - DATA: count rd_valid_i beats. After beat rd_len, go to NEXT.
  - NEXT: set full[half] and pulse buf_fill_o[half]; addr += len*BPB and half ^= 1. If addr >= top, pulse frame_done_o and go to IDLE; otherwise go to WAIT_BUF.
- Burst length: len = min(BURST_LEN, (top-addr)/BPB). The last burst may be partial; unwritten words of that half are stale.
- full[h] is cleared by buf_free_i[h]. A set in the same cycle wins. buf_free_i on an already-clear half is ignored.
- Each frame restarts at half 0. Full flags persist across frames.
- Restart: frame_start_i while busy pulses underrun_o and sets restart_pend.
  - In WAIT_BUF or REQ before the grant: return to IDLE and then restart immediately.
  - In DATA: drain the remaining beats (writes still performed), skip NEXT, then restart.
  - Pending restart uses the newly latched addresses and is gated by enable_i.
- Address arithmetic is modulo 2^ADDR_WIDTH. The comparison is unsigned.

## Timing
- Reset: state IDLE, half 0, full = 00, restart_pend 0. All outputs are 0.
- rd_req_o rises the cycle after entering REQ and falls the cycle after rd_gnt_i.
- Beat to buffer write latency is 1 cycle, registered (buf_we_o, buf_sel_o, buf_waddr_o, buf_wdata_o).
- buf_fill_o is asserted the cycle after the last buf_we_o of the burst. frame_done_o is asserted in the same cycle as the final buf_fill_o.
- With no back-pressure, burst-to-burst overhead is 3 cycles (NEXT, WAIT_BUF, REQ).
- rd_valid_i outside DATA is ignored.
- Reset mid-burst aborts immediately. The interconnect is reset together with this block.

## Configuration
- FB_FETCH_UNDERRUN_CNT_EN:
  - Defined: adds output underrun_cnt_o [15:0]. It increments on each underrun_o pulse, saturates at 0xFFFF, and resets to 0.
  - Undefined: the port and the counter are absent. underrun_o is unchanged.

## Structure
- Shared VGA package/header holds:
  - the state encoding (IDLE, WAIT_BUF, REQ, DATA, NEXT);
  - the BPB, LEN_W and IDX_W derivations.
- One sub-module, fb_fetch_addr_gen. It holds the current address, computes len and last, and advances on NEXT.

## Test plan
All cases use BURST_LEN=16, DATA_WIDTH=32.
- Full frame: base 0x1000, top 0x1100, buffers freed promptly.
  - Expect 4 requests at 0x1000, 0x1040, 0x1080, 0x10C0, each with len 16.
  - Halves 0, 1, 0, 1; 64 buffer writes.
  - frame_done_o comes with the 4th fill.
- Partial frame: top 0x1028. Expect one request at 0x1000 with len 10, waddr 0..9, buf_fill_o=01, frame_done_o.
- Empty frame: top == base = 0x2000. Expect frame_done_o 1 cycle after the start, no rd_req_o, busy_o stays 0.
- Back-pressure: buf_free_i never pulsed.
  - After 2 fills, the block holds in WAIT_BUF with rd_req_o=0.
  - buf_free_i=01 produces the 3rd request within 2 cycles.
- Restart: frame_start_i during DATA beat 5.
  - Expect underrun_o, the remaining 11 beats written, no fill pulse, and a new request at base.
  - underrun_cnt_o=1 when the macro is defined.
- Reset mid-REQ: rd_req_o=0 and busy_o=0 the next cycle. A following start fetches normally from half 0.
